// File: rtl/fp_reg_file.sv
// fp_reg_file: floating-point register file ($f0-$f31) for the FP ALU.
//   Supports single-word access and double (even/odd pair) access. In a pair,
//   the even register holds the high word and the odd register the low word.
//   An odd index used with isDouble=1 sets a sticky misalign flag.
// Ports:
//   clk, rst_n            clock; synchronous active-low reset
//   isDouble              1 = pair access on reads and write
//   rs_addr, rt_addr      operand-0 / operand-1 register indices
//   rd_addr, RegWrite     write index and enable
//   wdata_0, wdata_1      write word (single) / high word, low word (double)
//   rdata0_0, rdata0_1    operand-0 word / pair low word (0 when single)
//   rdata1_0, rdata1_1    operand-1 word / pair low word (0 when single)
//   misalign              sticky misaligned-double flag, cleared by reset
module fp_reg_file #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_REGS = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              isDouble,
    input  logic [ADDR_W-1:0] rs_addr,
    input  logic [ADDR_W-1:0] rt_addr,
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic              RegWrite,
    input  logic [DATA_W-1:0] wdata_0,
    input  logic [DATA_W-1:0] wdata_1,
    output logic [DATA_W-1:0] rdata0_0,
    output logic [DATA_W-1:0] rdata0_1,
    output logic [DATA_W-1:0] rdata1_0,
    output logic [DATA_W-1:0] rdata1_1,
    output logic              misalign
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];
    logic [DATA_W-1:0] regs_d [NUM_REGS];
    logic              misalign_q;
    logic              misalign_d;

    // Aligned pair indices: bit 0 forced, so an odd index selects its pair.
    logic [ADDR_W-1:0] rs_even, rs_odd;
    logic [ADDR_W-1:0] rt_even, rt_odd;
    logic [ADDR_W-1:0] rd_odd;

    assign rs_even = {rs_addr[ADDR_W-1:1], 1'b0};
    assign rs_odd  = {rs_addr[ADDR_W-1:1], 1'b1};
    assign rt_even = {rt_addr[ADDR_W-1:1], 1'b0};
    assign rt_odd  = {rt_addr[ADDR_W-1:1], 1'b1};
    assign rd_odd  = {rd_addr[ADDR_W-1:1], 1'b1};

    // Next-state array. An odd-indexed double write modifies nothing.
    always_comb begin
        regs_d = regs_q;
        if (RegWrite) begin
            if (!isDouble) begin
                regs_d[rd_addr] = wdata_0;
            end else if (!rd_addr[0]) begin
                regs_d[rd_addr] = wdata_0;
                regs_d[rd_odd]  = wdata_1;
            end
        end
    end

    always_comb begin
        misalign_d = misalign_q
                   | (isDouble & ((RegWrite & rd_addr[0]) | rs_addr[0] | rt_addr[0]));
    end

    // Reset wins over a same-edge write.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
            misalign_q <= 1'b0;
        end else begin
            regs_q     <= regs_d;
            misalign_q <= misalign_d;
        end
    end

    // Combinational reads from the array; no write-to-read bypass.
    always_comb begin
        if (isDouble) begin
            rdata0_0 = regs_q[rs_even];
            rdata0_1 = regs_q[rs_odd];
            rdata1_0 = regs_q[rt_even];
            rdata1_1 = regs_q[rt_odd];
        end else begin
            rdata0_0 = regs_q[rs_addr];
            rdata0_1 = '0;
            rdata1_0 = regs_q[rt_addr];
            rdata1_1 = '0;
        end
    end

    assign misalign = misalign_q;

endmodule

// File: tb/tb_fp_reg_file.sv
module tb_fp_reg_file;

    logic        clk;
    logic        rst_n;
    logic        isDouble;
    logic [4:0]  rs_addr, rt_addr, rd_addr;
    logic        RegWrite;
    logic [31:0] wdata_0, wdata_1;
    logic [31:0] rdata0_0, rdata0_1, rdata1_0, rdata1_1;
    logic        misalign;

    int n_checks = 0;
    int n_fail   = 0;

    fp_reg_file #(.DATA_W(32), .ADDR_W(5), .NUM_REGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .isDouble (isDouble),
        .rs_addr  (rs_addr),
        .rt_addr  (rt_addr),
        .rd_addr  (rd_addr),
        .RegWrite (RegWrite),
        .wdata_0  (wdata_0),
        .wdata_1  (wdata_1),
        .rdata0_0 (rdata0_0),
        .rdata0_1 (rdata0_1),
        .rdata1_0 (rdata1_0),
        .rdata1_1 (rdata1_1),
        .misalign (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: plain array of register values plus sticky flag.
    logic [31:0] m_reg [32];
    logic        m_mis;
    bit          m_valid = 1'b0;

    always @(posedge clk) begin
        int rd;
        rd = int'(rd_addr);
        if (rst_n === 1'b0) begin
            for (int i = 0; i < 32; i++) m_reg[i] = 32'h0;
            m_mis   = 1'b0;
            m_valid = 1'b1;
        end else if (m_valid) begin
            if (isDouble && ((RegWrite && (rd % 2 == 1)) ||
                             (int'(rs_addr) % 2 == 1) || (int'(rt_addr) % 2 == 1)))
                m_mis = 1'b1;
            if (RegWrite) begin
                if (!isDouble) begin
                    m_reg[rd] = wdata_0;
                end else if (rd % 2 == 0) begin
                    m_reg[rd]     = wdata_0;
                    m_reg[rd + 1] = wdata_1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: every negedge once the model has seen a reset.
    always @(negedge clk) begin
        int a0, a1;
        logic [31:0] e00, e01, e10, e11;
        if (m_valid) begin
            a0 = int'(rs_addr);
            a1 = int'(rt_addr);
            if (isDouble) begin
                e00 = m_reg[a0 - a0 % 2];
                e01 = m_reg[a0 - a0 % 2 + 1];
                e10 = m_reg[a1 - a1 % 2];
                e11 = m_reg[a1 - a1 % 2 + 1];
            end else begin
                e00 = m_reg[a0];
                e01 = 32'h0;
                e10 = m_reg[a1];
                e11 = 32'h0;
            end
            chk("model rdata0_0", rdata0_0, e00);
            chk("model rdata0_1", rdata0_1, e01);
            chk("model rdata1_0", rdata1_0, e10);
            chk("model rdata1_1", rdata1_1, e11);
            chk("model misalign", {31'h0, misalign}, {31'h0, m_mis});
        end
    end

    task automatic drive(input logic rst, input logic dbl, input int rs, input int rt,
                         input int rd, input logic we, input logic [31:0] w0,
                         input logic [31:0] w1);
        rst_n    = rst;
        isDouble = dbl;
        rs_addr  = 5'(rs);
        rt_addr  = 5'(rt);
        rd_addr  = 5'(rd);
        RegWrite = we;
        wdata_0  = w0;
        wdata_1  = w1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr1(input int rd, input logic [31:0] w);
        drive(1'b1, 1'b0, 0, 0, rd, 1'b1, w, 32'hFFFF_FFFF);
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        tick();
        tick();

        // 1: reset clears a written register and the flag
        wr1(5, 32'hDEAD_BEEF);
        drive(1'b0, 1'b0, 5, 0, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("pre-reset f5", rdata0_0, 32'hDEAD_BEEF);
        tick();
        drive(1'b1, 1'b0, 5, 0, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("reset f5", rdata0_0, 32'h0);
        chk("reset misalign", {31'h0, misalign}, 32'h0);
        tick();

        // 2: single write, no bypass
        drive(1'b1, 1'b0, 3, 3, 3, 1'b1, 32'h3F80_0000, 32'h1234_5678);
        @(negedge clk);
        chk("f3 old value", rdata0_0, 32'h0);
        tick();
        drive(1'b1, 1'b0, 3, 3, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("f3 new value", rdata0_0, 32'h3F80_0000);
        chk("f3 single rdata0_1", rdata0_1, 32'h0);
        tick();

        // 3: double write to aligned pair
        drive(1'b1, 1'b1, 0, 0, 4, 1'b1, 32'h3FF0_0000, 32'h0000_0001);
        tick();
        drive(1'b1, 1'b1, 4, 2, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("dbl f4 high", rdata0_0, 32'h3FF0_0000);
        chk("dbl f5 low", rdata0_1, 32'h0000_0001);
        chk("dbl clean misalign", {31'h0, misalign}, 32'h0);
        tick();

        // 4: misaligned double write leaves pair alone, sets sticky flag
        wr1(6, 32'h1111_1111);
        wr1(7, 32'h2222_2222);
        drive(1'b1, 1'b1, 6, 6, 7, 1'b1, 32'hAAAA_AAAA, 32'hBBBB_BBBB);
        tick();
        drive(1'b1, 1'b0, 6, 7, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("misalign wr f6", rdata0_0, 32'h1111_1111);
        chk("misalign wr f7", rdata1_0, 32'h2222_2222);
        chk("misalign set", {31'h0, misalign}, 32'h1);
        tick();
        wr1(10, 32'h4049_0FDB);
        drive(1'b1, 1'b1, 10, 4, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("misalign sticky", {31'h0, misalign}, 32'h1);
        tick();

        // 5: misaligned double read returns aligned pair
        drive(1'b0, 1'b0, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        tick();
        wr1(8, 32'h8888_0008);
        wr1(9, 32'h9999_0009);
        drive(1'b1, 1'b1, 9, 0, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("odd rd f8", rdata0_0, 32'h8888_0008);
        chk("odd rd f9", rdata0_1, 32'h9999_0009);
        chk("odd rd misalign pre", {31'h0, misalign}, 32'h0);
        tick();
        drive(1'b1, 1'b0, 0, 0, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("odd rd misalign post", {31'h0, misalign}, 32'h1);
        tick();

        // 6: reset beats a same-edge write
        wr1(2, 32'hCAFE_F00D);
        drive(1'b0, 1'b0, 2, 2, 2, 1'b1, 32'h1234_5678, 32'h0);
        tick();
        drive(1'b1, 1'b0, 2, 2, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("wr during reset f2", rdata0_0, 32'h0);
        tick();

        // $f0 writable; boundary pair $f30/$f31
        wr1(0, 32'h0000_00F0);
        drive(1'b1, 1'b1, 0, 0, 30, 1'b1, 32'h3030_3030, 32'h3131_3131);
        tick();
        drive(1'b1, 1'b1, 30, 0, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("f0 writable", rdata1_0, 32'h0000_00F0);
        chk("dbl f30", rdata0_0, 32'h3030_3030);
        chk("dbl f31", rdata0_1, 32'h3131_3131);
        tick();

        // Sweep: fill every pair by double writes, then read in both modes.
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, 1'b1, 0, 0, 2 * i, 1'b1, 32'hA000_0000 + 32'(i),
                  32'h5000_0000 + 32'(i));
            tick();
        end
        for (int i = 0; i < 32; i++) begin
            drive(1'b1, (i % 3 == 0), i, 31 - i, 0, 1'b0, 32'h0, 32'h0);
            tick();
        end
        drive(1'b1, 1'b0, 17, 16, 0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        chk("sweep f17", rdata0_0, 32'h5000_0008);
        chk("sweep f16", rdata1_0, 32'hA000_0008);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
